// File: rtl/fiber_pkg.sv
// Shared types and address-slicing constants for the fiber cache bank and its DRAM port.
package fiber_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dram_resp_state_t;

    // Bank and responder both derive the line index from the same offset width.
    localparam int BANK_DATA_WIDTH  = 16;
    localparam int LINE_OFFSET_BITS = $clog2(BANK_DATA_WIDTH);

    function automatic int line_offset_bits(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/fiber_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module fiber_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fiber_dram_responder.sv
// DRAM-side responder for one fiber cache bank: absorbs writebacks, answers fills
// from a word-addressed backing store after a fixed latency.
module fiber_dram_responder
    import fiber_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 64,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_nreset,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic                  i_rd_valid,
    output logic                  o_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [CNT_WIDTH-1:0]  o_wr_count,
    output logic [CNT_WIDTH-1:0]  o_rd_count
);

    localparam int OFF_W = line_offset_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

    dram_resp_state_t      state, state_next;
    logic [LAT_W-1:0]      cnt, cnt_next;
    logic [IDX_W-1:0]      idx, idx_q, load_idx;
    logic                  load_data;
    logic                  wr_fire, rd_fire, rd_done;
    logic                  unused_addr;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Offset and upper address bits are ignored, so lines alias modulo MEM_WORDS.
    assign idx         = i_addr[OFF_W +: IDX_W];
    assign unused_addr = ^i_addr;

    assign o_wr_ready = i_nreset && (state == IDLE);
    assign o_rd_ready = i_nreset && (state == IDLE) && !i_wr_valid;
    assign o_rd_valid = (state == RESP);

    assign wr_fire = i_wr_valid && o_wr_ready;
    assign rd_fire = i_rd_valid && o_rd_ready;
    assign rd_done = o_rd_valid && i_rd_ready;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_data  = 1'b0;
        load_idx   = idx_q;
        unique case (state)
            IDLE: begin
                if (rd_fire) begin
                    load_idx = idx;
                    if (READ_LATENCY == 1) begin
                        load_data  = 1'b1;
                        state_next = RESP;
                    end else begin
                        // cnt holds the WAIT edges still to pass before the data load.
                        cnt_next   = LAT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    load_data  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - LAT_W'(1);
                end
            end
            RESP: begin
                if (i_rd_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx_q     <= '0;
            o_rd_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (rd_fire)   idx_q     <= idx;
            if (load_data) o_rd_data <= mem[load_idx];
        end
    end

    // NOTE: the backing store has no reset; its contents survive i_nreset by design.
    always_ff @(posedge i_clk) begin
        if (wr_fire) mem[idx] <= i_wr_data;
    end

    fiber_sat_counter #(.WIDTH(CNT_WIDTH)) u_wr_count (
        .clk   (i_clk),
        .rst_n (i_nreset),
        .inc   (wr_fire),
        .count (o_wr_count)
    );

    fiber_sat_counter #(.WIDTH(CNT_WIDTH)) u_rd_count (
        .clk   (i_clk),
        .rst_n (i_nreset),
        .inc   (rd_done),
        .count (o_rd_count)
    );

endmodule

// File: tb/tb_fiber_dram_responder.sv
// Self-checking bench for fiber_dram_responder: vector table, corner sequences, and
// randomized traffic against a line-array reference model.
module tb_fiber_dram_responder;

    localparam int LAT   = 4;
    localparam int WORDS = 1024;
    localparam int OFF   = 4;

    logic        clk;
    logic        nreset;
    logic [63:0] addr;
    logic [15:0] wr_data;
    logic        wr_valid, wr_ready;
    logic        rd_req_valid, rd_req_ready;
    logic [15:0] rsp_data;
    logic        rsp_valid, rsp_ready;
    logic [15:0] wr_count, rd_count;

    logic [63:0] b_addr;
    logic [15:0] b_wr_data;
    logic        b_wr_valid, b_wr_ready;
    logic        b_rd_req_valid, b_rd_req_ready;
    logic [15:0] b_rsp_data;
    logic        b_rsp_valid, b_rsp_ready;
    logic [1:0]  b_wr_count, b_rd_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] model_mem   [WORDS];
    bit          model_known [WORDS];
    int          exp_wr = 0;
    int          exp_rd = 0;

    fiber_dram_responder dut (
        .i_clk      (clk),
        .i_nreset   (nreset),
        .i_addr     (addr),
        .i_wr_data  (wr_data),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_rd_valid (rd_req_valid),
        .o_rd_ready (rd_req_ready),
        .o_rd_data  (rsp_data),
        .o_rd_valid (rsp_valid),
        .i_rd_ready (rsp_ready),
        .o_wr_count (wr_count),
        .o_rd_count (rd_count)
    );

    fiber_dram_responder #(
        .MEM_WORDS    (16),
        .READ_LATENCY (1),
        .CNT_WIDTH    (2)
    ) dut_l1 (
        .i_clk      (clk),
        .i_nreset   (nreset),
        .i_addr     (b_addr),
        .i_wr_data  (b_wr_data),
        .i_wr_valid (b_wr_valid),
        .o_wr_ready (b_wr_ready),
        .i_rd_valid (b_rd_req_valid),
        .o_rd_ready (b_rd_req_ready),
        .o_rd_data  (b_rsp_data),
        .o_rd_valid (b_rsp_valid),
        .i_rd_ready (b_rsp_ready),
        .o_wr_count (b_wr_count),
        .o_rd_count (b_rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [63:0] a);
        return int'((a >> OFF) % 64'(WORDS));
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic do_write(input logic [63:0] a, input logic [15:0] d);
        addr     = a;
        wr_data  = d;
        wr_valid = 1'b1;
        #1;
        check("wr_ready_idle", 64'(wr_ready), 64'd1);
        tick;
        wr_valid = 1'b0;
        model_mem[idx_of(a)]   = d;
        model_known[idx_of(a)] = 1'b1;
        exp_wr = sat16(exp_wr + 1);
        check("wr_count", 64'(wr_count), 64'(exp_wr));
    endtask

    task automatic do_read(input logic [63:0] a, input int hold, input bit poke,
                           output logic [15:0] got);
        int          lat;
        logic [15:0] exp_d;
        bit          known;
        exp_d = model_mem[idx_of(a)];
        known = model_known[idx_of(a)];
        addr         = a;
        rd_req_valid = 1'b1;
        #1;
        check("rd_ready_idle", 64'(rd_req_ready), 64'd1);
        tick;
        rd_req_valid = 1'b0;
        addr         = {$urandom, $urandom};
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick;
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(LAT));
        got = rsp_data;
        if (known) check("rd_data", 64'(rsp_data), 64'(exp_d));
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                wr_valid = 1'b1;
                wr_data  = 16'($urandom);
            end
            #1;
            check("resp_hold_valid", 64'(rsp_valid), 64'd1);
            check("resp_hold_data", 64'(rsp_data), 64'(got));
            check("resp_hold_wr_ready", 64'(wr_ready), 64'd0);
            check("resp_hold_rd_ready", 64'(rd_req_ready), 64'd0);
            tick;
        end
        wr_valid  = 1'b0;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        exp_rd = sat16(exp_rd + 1);
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("idle_after_resp", 64'(wr_ready), 64'd1);
        check("rd_count", 64'(rd_count), 64'(exp_rd));
        check("wr_count_unchanged", 64'(wr_count), 64'(exp_wr));
    endtask

    typedef struct {
        bit          is_wr;
        logic [63:0] a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [15:0] got;
        logic [63:0] ra;
        bit          seen;

        vecs[0] = '{1'b1, 64'h20,                  16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 64'h4020,                16'h0000, 16'hA5A5};
        vecs[2] = '{1'b1, 64'h0,                   16'h0001, 16'h0000};
        vecs[3] = '{1'b1, 64'hF,                   16'h0002, 16'h0000};
        vecs[4] = '{1'b0, 64'h8,                   16'h0000, 16'h0002};
        vecs[5] = '{1'b1, 64'h3FF0,                16'hFFFF, 16'h0000};
        vecs[6] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 16'h0000, 16'hFFFF};
        vecs[7] = '{1'b1, 64'h10,                  16'h0000, 16'h0000};
        vecs[8] = '{1'b0, 64'h10,                  16'h0000, 16'h0000};
        vecs[9] = '{1'b0, 64'h30,                  16'h0000, 16'hBEEF};

        nreset = 1'b0;
        addr = '0; wr_data = '0; wr_valid = 1'b0; rd_req_valid = 1'b0; rsp_ready = 1'b0;
        b_addr = '0; b_wr_data = '0; b_wr_valid = 1'b0; b_rd_req_valid = 1'b0; b_rsp_ready = 1'b0;
        repeat (3) tick;
        nreset = 1'b1;
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        check("reset_wr_count", 64'(wr_count), 64'd0);
        check("reset_rd_count", 64'(rd_count), 64'd0);
        check("reset_wr_ready", 64'(wr_ready), 64'd1);
        check("reset_rd_ready", 64'(rd_req_ready), 64'd1);

        // Basic write then read with fixed latency.
        do_write(64'h30, 16'hBEEF);
        do_read(64'h30, 0, 1'b0, got);
        check("basic_read_data", 64'(got), 64'hBEEF);

        // Simultaneous write and fill request: write wins, read follows next cycle.
        addr = 64'h50; wr_data = 16'h1234; wr_valid = 1'b1; rd_req_valid = 1'b1;
        #1;
        check("prio_rd_ready", 64'(rd_req_ready), 64'd0);
        check("prio_wr_ready", 64'(wr_ready), 64'd1);
        tick;
        wr_valid = 1'b0;
        model_mem[5] = 16'h1234;
        model_known[5] = 1'b1;
        exp_wr = sat16(exp_wr + 1);
        check("prio_wr_count", 64'(wr_count), 64'(exp_wr));
        do_read(64'h50, 0, 1'b0, got);
        check("prio_read_data", 64'(got), 64'h1234);

        // Response held off for 10 cycles with a writeback knocking.
        do_read(64'h30, 10, 1'b1, got);
        check("hold_read_data", 64'(got), 64'hBEEF);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].a, vecs[i].d);
            end else begin
                do_read(vecs[i].a, i % 3, 1'b0, got);
                check($sformatf("vec%0d_data", i), 64'(got), 64'(vecs[i].exp));
            end
        end

        // Reset during WAIT: read is dropped, a write on the reset edge is discarded.
        do_write(64'h60, 16'h7777);
        addr = 64'h60; rd_req_valid = 1'b1;
        tick;
        rd_req_valid = 1'b0;
        tick;
        nreset = 1'b0;
        wr_valid = 1'b1; wr_data = 16'h9999;
        #1;
        check("inreset_wr_ready", 64'(wr_ready), 64'd0);
        check("inreset_rd_ready", 64'(rd_req_ready), 64'd0);
        tick;
        nreset = 1'b1;
        wr_valid = 1'b0;
        #1;
        exp_wr = 0;
        exp_rd = 0;
        check("postreset_rd_ready", 64'(rd_req_ready), 64'd1);
        check("postreset_wr_ready", 64'(wr_ready), 64'd1);
        check("postreset_wr_count", 64'(wr_count), 64'd0);
        check("postreset_rd_count", 64'(rd_count), 64'd0);
        check("postreset_rsp_data", 64'(rsp_data), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick;
        end
        check("dropped_read_no_resp", 64'(seen), 64'd0);
        do_read(64'h60, 0, 1'b0, got);
        check("store_survives_reset", 64'(got), 64'h7777);

        // Randomized traffic over a few lines with random upper and offset bits.
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            ra[13:4] = 10'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(ra, 16'($urandom));
            else
                do_read(ra, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        // READ_LATENCY=1, CNT_WIDTH=2 instance: counter saturation and one-cycle fill.
        for (int i = 0; i < 5; i++) begin
            b_addr = 64'(i) << OFF;
            b_wr_data = 16'h0100 + 16'(i);
            b_wr_valid = 1'b1;
            tick;
            b_wr_valid = 1'b0;
            check($sformatf("l1_sat_wr_count%0d", i), 64'(b_wr_count), 64'((i + 1 > 3) ? 3 : i + 1));
        end
        b_addr = 64'h20; b_rd_req_valid = 1'b1;
        #1;
        check("l1_rd_ready", 64'(b_rd_req_ready), 64'd1);
        tick;
        b_rd_req_valid = 1'b0;
        check("l1_valid_next_cycle", 64'(b_rsp_valid), 64'd1);
        check("l1_data", 64'(b_rsp_data), 64'h0102);
        b_rsp_ready = 1'b1;
        tick;
        b_rsp_ready = 1'b0;
        check("l1_valid_drop", 64'(b_rsp_valid), 64'd0);
        check("l1_rd_count", 64'(b_rd_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
